dmem_uart_tx: RTL and testbench
===============================

// Module: dmem_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the rv32i data-memory bus, downstream of the core's dmem_* outputs.
//  Core writes bytes into a TX FIFO with single-cycle stores. A bit-timing FSM serialises each byte as 8N1.
//  The core never stalls, so a store to a full FIFO is dropped and flagged.
//  Read data is combinational. Top level muxes dmem_r_data_o onto dmem_r_data_i whenever sel_o=1.
// PARAMETERS
//  BASE_ADDR   32'h0000_1000  register window base; window is 16 bytes, aligned to 16
//  CLK_DIV     16'd868        clk cycles per UART bit; legal minimum is 2
//  FIFO_AW     4              FIFO address width; depth = 2**FIFO_AW entries of 8 bits
// PORTS
//  clk            in   1   clock; all state changes on posedge
//  reset          in   1   asynchronous, active-high reset
//  dmem_addr_i    in   32  byte address, from core dmem_addr_o
//  dmem_w_i       in   1   write strobe, from core dmem_w_o
//  dmem_w_data_i  in   32  write data, from core dmem_w_data_o
//  dmem_r_data_o  out  32  combinational read data; 0 when sel_o=0
//  sel_o          out  1   combinational; high when dmem_addr_i[31:4]==BASE_ADDR[31:4]
//  tx_o           out  1   serial line; idle high
//  busy_o         out  1   high when state!=IDLE or FIFO not empty
// BEHAVIOUR
//  Register map (offset = dmem_addr_i[3:0]; any offset not listed reads 0 and ignores writes):
//   0x0 TXDATA  W: push dmem_w_data_i[7:0]. R: 0.
//   0x4 STATUS  R: {28'b0, overflow, busy, full, empty}. W: data bit3=1 clears overflow.
//   0x8 DIV     (present only with UART_DIV_REG_EN; see CONFIGURATION)
//  Writes take effect on the posedge where sel_o & dmem_w_i are both high.
//  FIFO push/pop rules:
//   - Push accepted if count < depth, or if a pop occurs on the same edge.
//   - Otherwise the byte is dropped and overflow is set (sticky).
//   - Set beats clear when both occur on the same edge.
//   - Pointers wrap modulo depth. Count is FIFO_AW+1 bits wide.
//  FSM states: IDLE, START, DATA, STOP. Bit counter bit_cnt[2:0]. Baud counter reloads to div-1 and counts down.
//   - IDLE: tx_o=1. If FIFO not empty: pop into shift reg, reload baud counter, go START.
//   - START: tx_o=0. When baud counter==0: reload, bit_cnt=0, go DATA.
//   - DATA: tx_o=shift[0] (LSB first). When baud counter==0: shift right, reload. Go STOP after bit_cnt==7.
//   - STOP: tx_o=1. When baud counter==0: if FIFO not empty, pop and go START; else go IDLE.
//  Timing:
//   - Each bit lasts exactly div cycles. A frame lasts 10*div cycles.
//   - Back-to-back frames have zero idle cycles between them.
//   - Latency: a push into an empty, idle block on edge N pops on edge N+1; tx_o falls after edge N+1.
//  tx_o and busy_o are registered or decoded from registered state. No combinational path from dmem_* to tx_o.
//  Reset values: tx_o=1, busy_o=0, state=IDLE, FIFO empty, overflow=0, counters=0, div=CLK_DIV.
//   - STATUS therefore reads 32'h1 immediately after reset.
//  Reset asserted mid-frame: tx_o goes to 1 at once without waiting for a clock edge.
//   - The frame is aborted and the FIFO is flushed. No partial frame resumes after release.
// CONFIGURATION
//  Macro UART_DIV_REG_EN:
//   - Defined: offset 0x8 is a 16-bit DIV register, reset value CLK_DIV.
//     - W: div=dmem_w_data_i[15:0]; values <2 are stored as 2. R: {16'b0, div}.
//     - A new value is used from the next baud-counter reload, so a bit in progress is never shortened.
//   - Undefined: div is the constant CLK_DIV. Offset 0x8 reads {16'b0, CLK_DIV} and ignores writes.
// TESTING  (CLK_DIV=4, FIFO_AW=4, BASE_ADDR=32'h1000)
//  1. Reset pulse, no clock edges -> tx_o=1, busy_o=0. Read 0x1004 -> 32'h1, sel_o=1. Read 0x2000 -> sel_o=0, data 0.
//  2. Write 0x55 to 0x1000 -> tx_o falls 1 cycle later. Bits 1,0,1,0,1,0,1,0 for 4 cycles each, stop 4 cycles (40 total).
//     Then busy_o=0 and STATUS=32'h1.
//  3. Write 0x01, 0x80, 0xFF on consecutive cycles -> 3 contiguous frames, 120 cycles, no high gap between stop and start.
//  4. Write 17 bytes on consecutive cycles -> STATUS=32'h6 (full, busy), overflow=0.
//     18th write -> dropped, STATUS=32'hE. Write 0x8 to 0x1004 -> STATUS=32'h6.
//     The 16 queued bytes plus the one in flight are transmitted in order.
//  5. Reset asserted mid DATA bit 3 -> tx_o=1 with no clock edge. After release, STATUS=32'h1 and no further frames.
//  6. UART_DIV_REG_EN defined: write 6 to 0x1008 -> next frame is 60 cycles; write 1 -> reads back 2.
//     Undefined: write to 0x1008 is ignored; read returns 32'h4.

Source files
------------

// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the rv32i data-memory bus, with a byte FIFO and a sticky overflow flag.
// Optional macro UART_DIV_REG_EN adds a writable baud divisor at offset 0x8; otherwise the divisor is CLK_DIV.
module dmem_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [15:0] CLK_DIV   = 16'd868,
  parameter int          FIFO_AW   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_addr_i,
  input  logic        dmem_w_i,
  input  logic [31:0] dmem_w_data_i,
  output logic [31:0] dmem_r_data_o,
  output logic        sel_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [3:0]         offset;
  logic               wr_en;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               ovf_clr;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic               empty;
  logic               full;
  logic [1:0]         state;
  logic [2:0]         bit_cnt;
  logic [15:0]        baud;
  logic               baud_zero;
  logic [7:0]         shift;
  logic [15:0]        div;
  logic [15:0]        div_m1;
  logic               unused_wdata;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

  assign offset       = dmem_addr_i[3:0];
  assign sel_o        = (dmem_addr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_en        = sel_o & dmem_w_i;
  assign unused_wdata = ^dmem_w_data_i[31:8];

  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  assign baud_zero = (baud == '0);
  assign div_m1    = div - 16'd1;

  // A pop frees a slot on the same edge, so a push into a full FIFO still lands then.
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && baud_zero));
  assign push_req = wr_en && (offset == 4'h0);
  assign push     = push_req && (!full || pop);
  assign ovf_clr  = wr_en && (offset == 4'h4) && dmem_w_data_i[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
      if (push_req && !push) overflow <= 1'b1;
      else if (ovf_clr)      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dmem_w_data_i[7:0];
  end

`ifdef UART_DIV_REG_EN
  // The divisor is only sampled on a baud-counter reload, so a bit in progress keeps its length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           div <= CLK_DIV;
    else if (wr_en && (offset == 4'h8))  div <= clamp_div(dmem_w_data_i[15:0]);
  end
`else
  assign div = CLK_DIV;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      baud    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state <= START;
            baud  <= div_m1;
          end
        end
        START: begin
          if (baud_zero) begin
            baud    <= div_m1;
            bit_cnt <= '0;
            state   <= DATA;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        DATA: begin
          if (baud_zero) begin
            baud <= div_m1;
            if (bit_cnt == 3'd7) state   <= STOP;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        STOP: begin
          if (baud_zero) begin
            if (!empty) begin
              state <= START;
              baud  <= div_m1;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop)                              shift <= mem[rd_ptr];
    else if ((state == DATA) && baud_zero) shift <= {1'b0, shift[7:1]};
  end

  // Line level is decoded from state alone, so reset drives it high without a clock edge.
  always_comb begin
    case (state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift[0];
      default: tx_o = 1'b1;
    endcase
  end

  assign busy_o = (state != IDLE) || !empty;

  always_comb begin
    dmem_r_data_o = '0;
    if (sel_o) begin
      case (offset)
        4'h4:    dmem_r_data_o = {28'b0, overflow, busy_o, full, empty};
        4'h8:    dmem_r_data_o = {16'b0, div};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Bench for dmem_uart_tx: register vector table plus a serial-line decoder that checks frames against a byte scoreboard.
module tb_dmem_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [15:0] DIV  = 16'd4;
`ifdef UART_DIV_REG_EN
  localparam bit DIV_REG = 1'b1;
`else
  localparam bit DIV_REG = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] dmem_addr;
  logic        dmem_w;
  logic [31:0] dmem_w_data;
  logic [31:0] dmem_r_data;
  logic        sel;
  logic        tx;
  logic        busy;

  dmem_uart_tx #(
    .BASE_ADDR(BASE),
    .CLK_DIV  (DIV),
    .FIFO_AW  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dmem_addr_i  (dmem_addr),
    .dmem_w_i     (dmem_w),
    .dmem_w_data_i(dmem_w_data),
    .dmem_r_data_o(dmem_r_data),
    .sel_o        (sel),
    .tx_o         (tx),
    .busy_o       (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bit_len = 4;
  int frames_seen = 0;
  byte unsigned sb[$];
  int frame_starts[$];

  int k = -1;
  logic [9:0] bits;
  bit glitch;
  byte unsigned exp_b;

  typedef struct {
    logic [31:0] addr;
    logic        w;
    logic [31:0] wdata;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [18];

  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 32'h%08h, expected 32'h%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d);
    dmem_addr   = a;
    dmem_w      = w;
    dmem_w_data = d;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (((busy !== 1'b0) || (k >= 0)) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if ((busy !== 1'b0) || (k >= 0)) begin
      fails++;
      $display("FAIL %s: got busy=%b after %0d cycles, expected idle", name, busy, budget);
    end
  endtask

  // Serial decoder: one sample per cycle, each bit must hold for bit_len samples.
  always @(negedge clk) begin
    if (reset) begin
      k = -1;
      glitch = 1'b0;
    end else if (k < 0) begin
      if (tx === 1'b0) begin
        k = 0;
        bits = '0;
        glitch = 1'b0;
        frame_starts.push_back(cyc);
      end
    end else begin
      k = k + 1;
      if ((k % bit_len) == 0) bits[k / bit_len] = tx;
      else if (tx !== bits[k / bit_len]) glitch = 1'b1;
      if (k == 10 * bit_len - 1) begin
        frames_seen++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL frame: got byte 8'h%02h, expected no frame (scoreboard empty)", bits[8:1]);
        end else begin
          exp_b = sb.pop_front();
          if (glitch || (bits[0] !== 1'b0) || (bits[9] !== 1'b1) || (bits[8:1] !== exp_b)) begin
            fails++;
            $display("FAIL frame: got 8'h%02h start=%b stop=%b glitch=%b, expected 8'h%02h start=0 stop=1 glitch=0",
                     bits[8:1], bits[0], bits[9], glitch, exp_b);
          end
        end
        k = -1;
      end
    end
  end

  initial begin
    int fb;
    int lows;

    vecs[0]  = '{BASE + 32'h4,  1'b0, 32'h0,        1'b1, 32'h1};
    vecs[1]  = '{32'h0000_2000, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{BASE,          1'b0, 32'h0,        1'b1, 32'h0};
    vecs[3]  = '{BASE + 32'h8,  1'b0, 32'h0,        1'b1, 32'h4};
    vecs[4]  = '{BASE + 32'hC,  1'b0, 32'h0,        1'b1, 32'h0};
    vecs[5]  = '{32'h0000_0FFC, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[6]  = '{32'h0000_1014, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[7]  = '{BASE + 32'hC,  1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[8]  = '{BASE + 32'h4,  1'b1, 32'h8,        1'b1, 32'h1};
    vecs[9]  = '{BASE + 32'h8,  1'b1, 32'h6,        1'b1, 32'h4};
    vecs[10] = '{BASE + 32'h8,  1'b1, 32'h1,        1'b1, DIV_REG ? 32'h6 : 32'h4};
    vecs[11] = '{BASE + 32'h8,  1'b1, 32'h4,        1'b1, DIV_REG ? 32'h2 : 32'h4};
    vecs[12] = '{BASE + 32'h8,  1'b0, 32'h0,        1'b1, 32'h4};
    vecs[13] = '{BASE + 32'h4,  1'b0, 32'h0,        1'b1, 32'h1};
    vecs[14] = '{32'h0000_2000, 1'b1, 32'h41,       1'b0, 32'h0};
    vecs[15] = '{BASE + 32'h4,  1'b0, 32'h0,        1'b1, 32'h1};
    vecs[16] = '{BASE + 32'h1,  1'b1, 32'h33,       1'b1, 32'h0};
    vecs[17] = '{BASE + 32'h4,  1'b0, 32'h0,        1'b1, 32'h1};

    // Reset pulse with no clock edges yet.
    reset = 1'b0;
    bus(BASE + 32'h4, 1'b0, 32'h0);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_status", dmem_r_data, 32'h1);
    check("rst_sel", sel, 1);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      bus(vecs[i].addr, vecs[i].w, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d_sel", i), sel, vecs[i].exp_sel);
      check($sformatf("vec%0d_rd", i), dmem_r_data, vecs[i].exp_rd);
    end
    @(negedge clk);
    bus(BASE + 32'h4, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    #1 check("table_idle", busy, 0);

    // Single frame: latency and total length.
    @(negedge clk);
    bus(BASE, 1'b1, 32'h55);
    sb.push_back(8'h55);
    @(negedge clk);
    bus(BASE + 32'h4, 1'b0, 32'h0);
    #1 check("t2_tx_before_pop", tx, 1);
    @(negedge clk);
    #1 check("t2_tx_start", tx, 0);
    repeat (39) @(negedge clk);
    #1;
    check("t2_busy_in_stop", busy, 1);
    check("t2_tx_stop", tx, 1);
    @(negedge clk);
    #1;
    check("t2_busy_done", busy, 0);
    check("t2_status_done", dmem_r_data, 32'h1);

    // Three back-to-back frames.
    frame_starts.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fb = (i == 0) ? 8'h01 : ((i == 1) ? 8'h80 : 8'hFF);
      bus(BASE, 1'b1, 32'(fb));
      sb.push_back(8'(fb));
    end
    @(negedge clk);
    bus(BASE + 32'h4, 1'b0, 32'h0);
    wait_idle("t3_drain", 300);
    check("t3_frames", frame_starts.size(), 3);
    if (frame_starts.size() == 3) begin
      check("t3_gap01", frame_starts[1] - frame_starts[0], 40);
      check("t3_gap12", frame_starts[2] - frame_starts[1], 40);
    end

    // Fill to full, overflow, clear, drain in order.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus(BASE, 1'b1, 32'(16 + i));
      sb.push_back(8'(16 + i));
    end
    @(negedge clk);
    bus(BASE + 32'h4, 1'b0, 32'h0);
    #1 check("t4_full", dmem_r_data, 32'h6);
    bus(BASE, 1'b1, 32'hEE);
    @(negedge clk);
    bus(BASE + 32'h4, 1'b0, 32'h0);
    #1 check("t4_overflow", dmem_r_data, 32'hE);
    bus(BASE + 32'h4, 1'b1, 32'h8);
    @(negedge clk);
    bus(BASE + 32'h4, 1'b0, 32'h0);
    #1 check("t4_cleared", dmem_r_data, 32'h6);
    wait_idle("t4_drain", 1500);
    #1 check("t4_status_done", dmem_r_data, 32'h1);

    // Reset in the middle of data bit 3.
    @(negedge clk);
    bus(BASE, 1'b1, 32'hA5);
    sb.push_back(8'hA5);
    @(negedge clk);
    bus(BASE + 32'h4, 1'b0, 32'h0);
    repeat (18) @(negedge clk);
    #1 check("t5_tx_bit3", tx, 0);
    #1 reset = 1'b1;
    #1;
    check("t5_tx_async", tx, 1);
    check("t5_busy_async", busy, 0);
    sb.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    check("t5_status", dmem_r_data, 32'h1);
    fb = frames_seen;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("t5_line_quiet", lows, 0);
    check("t5_no_frames", frames_seen, fb);

`ifdef UART_DIV_REG_EN
    // Programmed divisor stretches the next frame to 60 cycles.
    @(negedge clk);
    bus(BASE + 32'h8, 1'b1, 32'h6);
    @(negedge clk);
    bus(BASE + 32'h8, 1'b0, 32'h0);
    #1 check("t6_div_rd", dmem_r_data, 32'h6);
    bit_len = 6;
    frame_starts.delete();
    @(negedge clk);
    bus(BASE, 1'b1, 32'h3C);
    sb.push_back(8'h3C);
    @(negedge clk);
    bus(BASE + 32'h4, 1'b0, 32'h0);
    repeat (60) @(negedge clk);
    #1 check("t6_busy_60", busy, 1);
    @(negedge clk);
    #1 check("t6_idle_61", busy, 0);
    wait_idle("t6_drain", 100);
    check("t6_frames", frame_starts.size(), 1);
    @(negedge clk);
    bus(BASE + 32'h8, 1'b1, 32'h4);
    @(negedge clk);
    bus(BASE + 32'h4, 1'b0, 32'h0);
    bit_len = 4;
`endif

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
